// File: rtl/freq_measure_ctrl.sv
// Gated edge counter: counts INPUT_CLK rising edges over a GATE_CYCLES window
// started by a KEY1 press, and reports a saturated result with a one-cycle valid.
`timescale 1ns/1ps
module freq_measure_ctrl #(
  parameter int GATE_CYCLES = 50_000_000,
  parameter int MAX_DISPLAY = 999
) (
  input  logic       MAX10_CLK1_50,
  input  logic       KEY0,
  input  logic       INPUT_CLK,
  input  logic       KEY1,
  input  logic       cont_mode,
  output logic [9:0] freq_value,
  output logic       overflow,
  output logic       no_signal,
  output logic       valid,
  output logic       busy
);
  localparam int CW = 26;
  localparam int TW = $clog2(GATE_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST = TW'(GATE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ARM, GATE, LATCH} state_t;
  state_t state, state_nxt;

  logic [2:0]    sig_sync, key_sync;
  logic          sig_rise, start_evt;
  logic [TW-1:0] tcnt, gcnt;
  logic [CW-1:0] edge_cnt, edge_inc;
  logic          timeout, gate_done;

  // [0],[1] synchronize, [2] holds the previous synchronized level; events are registered
  always_ff @(posedge MAX10_CLK1_50 or negedge KEY0) begin
    if (!KEY0) begin
      sig_sync  <= '0;
      key_sync  <= '0;
      sig_rise  <= 1'b0;
      start_evt <= 1'b0;
    end else begin
      sig_sync  <= {sig_sync[1:0], INPUT_CLK};
      key_sync  <= {key_sync[1:0], KEY1};
      sig_rise  <= sig_sync[1] & ~sig_sync[2];
      start_evt <= ~key_sync[1] & key_sync[2];
    end
  end

  assign edge_inc = (sig_rise && edge_cnt != '1) ? edge_cnt + CW'(1) : edge_cnt;

  always_comb begin
    state_nxt = state;
    timeout   = 1'b0;
    gate_done = 1'b0;
    case (state)
      IDLE:  if (start_evt) state_nxt = ARM;
      ARM: begin
        if (sig_rise) state_nxt = GATE;
        else if (tcnt == T_LAST) begin
          state_nxt = LATCH;
          timeout   = 1'b1;
        end
      end
      GATE: begin
        if (gcnt == T_LAST) begin
          state_nxt = LATCH;
          gate_done = 1'b1;
        end
      end
      LATCH:   state_nxt = cont_mode ? ARM : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Results load on entry to LATCH so they are already current while valid is high
  always_ff @(posedge MAX10_CLK1_50 or negedge KEY0) begin
    if (!KEY0) begin
      state      <= IDLE;
      tcnt       <= '0;
      gcnt       <= '0;
      edge_cnt   <= '0;
      freq_value <= '0;
      overflow   <= 1'b0;
      no_signal  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        ARM: begin
          tcnt     <= tcnt + TW'(1);
          gcnt     <= '0;
          edge_cnt <= '0;
        end
        GATE: begin
          gcnt     <= gcnt + TW'(1);
          edge_cnt <= edge_inc;
        end
        default: tcnt <= '0;
      endcase
      if (timeout) begin
        freq_value <= '0;
        overflow   <= 1'b0;
        no_signal  <= 1'b1;
      end else if (gate_done) begin
        freq_value <= (edge_inc > CW'(MAX_DISPLAY)) ? 10'(MAX_DISPLAY) : edge_inc[9:0];
        overflow   <= (edge_inc > CW'(MAX_DISPLAY));
        no_signal  <= 1'b0;
      end
    end
  end

  assign valid = (state == LATCH);
  assign busy  = (state != IDLE);
endmodule

// File: tb/tb_freq_measure_ctrl.sv
// Bench for freq_measure_ctrl: timestamp-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
`timescale 1ns/1ps
module tb_freq_measure_ctrl;
  localparam int GC   = 100;
  localparam int MAXC = 32768;
  localparam int LAT  = 3;
  localparam int M_IDLE = 0, M_WAIT = 1, M_WIN = 2, M_REP = 3;

  logic clk = 1'b0, KEY0 = 1'b0, INPUT_CLK = 1'b0, KEY1 = 1'b1, cont_mode = 1'b0;
  logic [9:0] fa, fb;
  logic oa, ob, na, nb, va, vb, ba, bb;

  always #10 clk = ~clk;

  freq_measure_ctrl #(.GATE_CYCLES(GC), .MAX_DISPLAY(999)) dut_a (
    .MAX10_CLK1_50(clk), .KEY0(KEY0), .INPUT_CLK(INPUT_CLK), .KEY1(KEY1),
    .cont_mode(cont_mode), .freq_value(fa), .overflow(oa), .no_signal(na),
    .valid(va), .busy(ba));
  freq_measure_ctrl #(.GATE_CYCLES(GC), .MAX_DISPLAY(20)) dut_b (
    .MAX10_CLK1_50(clk), .KEY0(KEY0), .INPUT_CLK(INPUT_CLK), .KEY1(KEY1),
    .cont_mode(cont_mode), .freq_value(fb), .overflow(ob), .no_signal(nb),
    .valid(vb), .busy(bb));

  int n_chk = 0, n_fail = 0;
  int cyc = 0;

  task automatic check(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Signal source: 0 = held low, 1 = periodic (rise every sig_per cycles), 2 = random
  int sig_mode = 0, sig_per = 10, ph = 0;
  always @(posedge clk) begin
    #1;
    case (sig_mode)
      0: INPUT_CLK = 1'b0;
      1: begin
        INPUT_CLK = (ph < sig_per / 2);
        ph = (ph + 1 >= sig_per) ? 0 : ph + 1;
      end
      default: if ($urandom_range(0, 3) == 0) INPUT_CLK = ~INPUT_CLK;
    endcase
  end

  // Reference model: events are timestamped with the posedge that consumes them,
  // measurement phases are tracked by their start time, counts are window sums.
  bit rise_at[MAXC];
  bit start_at[MAXC];
  int m_mode = M_IDLE, m_t0 = 0, m_n = 0;
  int e_fa = 0, e_fb = 0, e_oa = 0, e_ob = 0, e_n = 0;
  bit m_prev_sig = 0, m_prev_key = 0;

  always @(posedge clk) begin
    cyc++;
    if (cyc > MAXC - 8) begin
      $display("FAIL cycle_budget: actual %0d required below %0d", cyc, MAXC - 8);
      $fatal(1, "cycle budget exhausted");
    end
    if (!KEY0) begin
      m_mode = M_IDLE;
      e_fa = 0; e_fb = 0; e_oa = 0; e_ob = 0; e_n = 0;
      m_prev_sig = 0; m_prev_key = 0;
      for (int i = 0; i <= LAT; i++) begin
        rise_at[cyc + i] = 0;
        start_at[cyc + i] = 0;
      end
    end else begin
      case (m_mode)
        M_IDLE: if (start_at[cyc]) begin m_mode = M_WAIT; m_t0 = cyc; end
        M_WAIT: begin
          if (rise_at[cyc]) begin m_mode = M_WIN; m_t0 = cyc; end
          else if (cyc - m_t0 == GC) begin
            m_mode = M_REP;
            e_fa = 0; e_fb = 0; e_oa = 0; e_ob = 0; e_n = 1;
          end
        end
        M_WIN: begin
          if (cyc - m_t0 == GC) begin
            m_n = 0;
            for (int i = m_t0 + 1; i <= cyc; i++) m_n += int'(rise_at[i]);
            e_fa = (m_n > 999) ? 999 : m_n;
            e_oa = int'(m_n > 999);
            e_fb = (m_n > 20) ? 20 : m_n;
            e_ob = int'(m_n > 20);
            e_n  = 0;
            m_mode = M_REP;
          end
        end
        default: begin
          if (cont_mode) begin m_mode = M_WAIT; m_t0 = cyc; end
          else m_mode = M_IDLE;
        end
      endcase
      if (INPUT_CLK && !m_prev_sig) rise_at[cyc + LAT] = 1;
      if (!KEY1 && m_prev_key) start_at[cyc + LAT] = 1;
      m_prev_sig = INPUT_CLK;
      m_prev_key = KEY1;
    end
  end

  always @(negedge clk) begin
    if (KEY0) begin
      check("busy_a", ba, m_mode != M_IDLE);
      check("busy_b", bb, m_mode != M_IDLE);
      check("valid_a", va, m_mode == M_REP);
      check("valid_b", vb, m_mode == M_REP);
      check("freq_a", fa, e_fa);
      check("freq_b", fb, e_fb);
      check("ovf_a", oa, e_oa);
      check("ovf_b", ob, e_ob);
      check("nosig_a", na, e_n);
      check("nosig_b", nb, e_n);
    end
  end

  int vcnt = 0, last_vcyc = 0, last_fa = 0, last_fb = 0, last_oa = 0, last_ob = 0, last_na = 0;
  always @(negedge clk) begin
    if (va) begin
      vcnt++;
      last_vcyc = cyc;
      last_fa = fa; last_fb = fb; last_oa = oa; last_ob = ob; last_na = na;
    end
  end

  int press_cyc = 0;
  task automatic press();
    @(posedge clk); #1 KEY1 = 1'b0; press_cyc = cyc;
    repeat (3) @(posedge clk);
    #1 KEY1 = 1'b1;
  endtask

  task automatic wait_valid(input string nm, input int budget);
    int v0 = vcnt;
    int k = 0;
    while (vcnt == v0 && k < budget) begin @(posedge clk); k++; end
    check({nm, "_valid_seen"}, vcnt - v0, 1);
  endtask

  task automatic set_sig(input int mode, input int per);
    @(posedge clk); #2;
    sig_mode = mode; sig_per = per;
    repeat (2 * per + 10) @(posedge clk);
  endtask

  int v_before;
  initial begin
    // reset state
    #15;
    check("rst_busy", ba, 0); check("rst_valid", va, 0);
    check("rst_freq", fa, 0); check("rst_ovf", oa, 0); check("rst_nosig", na, 0);
    repeat (3) @(posedge clk);
    #1 KEY0 = 1'b1;
    repeat (5) @(posedge clk);

    // basic measurement: period 10 -> 10 edges per 100-cycle gate
    set_sig(1, 10);
    press();
    wait_valid("basic", 400);
    check("basic_freq", last_fa, 10); check("basic_ovf", last_oa, 0);
    check("basic_nosig", last_na, 0); check("model_basic", e_fa, 10);
    repeat (3) @(posedge clk);
    #1 check("basic_idle", ba, 0);

    // no signal: valid 100 cycles after ARM entry (start consumed LAT+1 posedges after drive)
    set_sig(0, 10);
    press();
    wait_valid("nosig", 400);
    check("nosig_latency", last_vcyc - press_cyc, GC + LAT + 1);
    check("nosig_flag", last_na, 1); check("nosig_freq", last_fa, 0);
    check("model_nosig", e_n, 1);

    // saturation: period 4 -> 25 edges
    set_sig(1, 4);
    press();
    wait_valid("sat", 400);
    check("sat_freq_b", last_fb, 20); check("sat_ovf_b", last_ob, 1);
    check("sat_freq_a", last_fa, 25); check("sat_ovf_a", last_oa, 0);
    check("model_sat", e_fb, 20);

    // continuous mode, then clear mid-gate
    set_sig(1, 5);
    #1 cont_mode = 1'b1;
    press();
    for (int i = 0; i < 3; i++) begin
      wait_valid("cont", 400);
      check("cont_freq", last_fa, 20);
    end
    repeat (50) @(posedge clk);
    #1 cont_mode = 1'b0;
    wait_valid("cont_last", 400);
    check("cont_last_freq", last_fa, 20);
    v_before = vcnt;
    repeat (250) @(posedge clk);
    check("cont_stopped", vcnt - v_before, 0);
    #1 check("cont_idle", ba, 0);

    // reset mid-gate
    set_sig(1, 10);
    press();
    repeat (60) @(posedge clk);
    v_before = vcnt;
    #1 KEY0 = 1'b0;
    #1;
    check("midrst_busy", ba, 0); check("midrst_freq", fa, 0); check("midrst_freq_b", fb, 0);
    check("midrst_valid", va, 0); check("midrst_ovf_b", ob, 0); check("midrst_nosig", na, 0);
    repeat (3) @(posedge clk);
    #1 KEY0 = 1'b1;
    repeat (200) @(posedge clk);
    check("midrst_no_valid", vcnt - v_before, 0);
    press();
    wait_valid("after_rst", 400);
    check("after_rst_freq", last_fa, 10);

    // second start during GATE is ignored
    v_before = vcnt;
    press();
    repeat (40) @(posedge clk);
    press();
    repeat (300) @(posedge clk);
    check("ignore_one_valid", vcnt - v_before, 1);
    check("ignore_freq", last_fa, 10);

    // randomized traffic against the model
    for (int it = 0; it < 25; it++) begin
      @(posedge clk); #2;
      case ($urandom_range(0, 3))
        0: sig_mode = 0;
        3: sig_mode = 2;
        default: begin sig_mode = 1; sig_per = $urandom_range(2, 30); end
      endcase
      cont_mode = ($urandom_range(0, 3) == 0);
      press();
      repeat ($urandom_range(50, 300)) @(posedge clk);
      if ($urandom_range(0, 5) == 0) begin
        #1 KEY0 = 1'b0;
        repeat (2) @(posedge clk);
        #1 KEY0 = 1'b1;
      end
      if ($urandom_range(0, 1) == 1) press();
      repeat ($urandom_range(20, 200)) @(posedge clk);
      #1 cont_mode = 1'b0;
    end
    repeat (300) @(posedge clk);
    #1 check("final_idle", ba, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/freq_measure_ctrl.md
FREQ_MEASURE_CTRL -- requirements
Module: freq_measure_ctrl

Interface
REQ-001 The block SHALL have parameter GATE_CYCLES, default 50_000_000, giving the gate window length in MAX10_CLK1_50 cycles (1 s at 50 MHz).
REQ-002 The block SHALL have parameter MAX_DISPLAY, default 999, giving the saturation limit of the reported count.
REQ-003 The block SHALL have port MAX10_CLK1_50  input  1  system clock; the only clock in the block.
REQ-004 The block SHALL have port KEY0  input  1  reset; asynchronous, active-low.
REQ-005 The block SHALL have port INPUT_CLK  input  1  signal under measurement; asynchronous to MAX10_CLK1_50.
REQ-006 The block SHALL have port KEY1  input  1  start pushbutton, active-low, asynchronous.
REQ-007 The block SHALL have port cont_mode  input  1  continuous re-measure enable, quasi-static.
REQ-008 The block SHALL have port freq_value  output  10  last measured edge count, saturated to MAX_DISPLAY.
REQ-009 The block SHALL have port overflow  output  1  last measurement exceeded MAX_DISPLAY.
REQ-010 The block SHALL have port no_signal  output  1  last measurement timed out waiting for the first edge.
REQ-011 The block SHALL have port valid  output  1  one-cycle pulse when freq_value, overflow and no_signal update.
REQ-012 The block SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-013 INPUT_CLK and KEY1 SHALL each pass through a 2-FF synchronizer and then an edge-detect register.
REQ-014 An INPUT_CLK rising-edge event (sig_rise) SHALL be asserted 3 cycles after the edge is first sampled.
REQ-015 A KEY1 falling-edge event (start_evt) SHALL be asserted with the same 3-cycle latency.
REQ-016 The FSM SHALL have states IDLE, ARM, GATE, LATCH.
REQ-017 In IDLE, start_evt SHALL move the FSM to ARM on the next cycle; all other inputs SHALL be ignored.
REQ-018 In ARM, the timeout counter SHALL increment every cycle.
REQ-019 In ARM, sig_rise SHALL clear the edge counter and the gate counter and move the FSM to GATE.
REQ-020 In ARM, if the timeout counter reaches GATE_CYCLES-1 with no sig_rise, the FSM SHALL move to LATCH with the no-signal result selected.
REQ-021 In GATE, the gate counter SHALL increment every cycle, with cycle g=1 being the first cycle after the ARM edge.
REQ-022 In GATE, sig_rise SHALL increment the 26-bit edge counter, and the edge counter SHALL saturate at all-ones.
REQ-023 After cycle g=GATE_CYCLES, including any edge that occurs on that cycle, the FSM SHALL move to LATCH.
REQ-024 LATCH SHALL last exactly one cycle and assert valid.
REQ-025 In LATCH, freq_value SHALL be loaded with min(edge_count, MAX_DISPLAY).
REQ-026 In LATCH, overflow SHALL be set to (edge_count > MAX_DISPLAY).
REQ-027 In LATCH, no_signal SHALL be set to 1 and freq_value to 0 if the no-signal result is selected.
REQ-028 In LATCH, no_signal SHALL be set to 0 if a gate window completed.
REQ-029 From LATCH, the FSM SHALL go to ARM if cont_mode=1, otherwise to IDLE.
REQ-030 The timeout counter SHALL be cleared on every entry to ARM.
REQ-031 start_evt in ARM, GATE or LATCH SHALL be ignored and SHALL NOT restart the measurement.
REQ-032 cont_mode SHALL be sampled only in LATCH; clearing it mid-measurement SHALL let the current measurement complete.
REQ-033 freq_value, overflow and no_signal SHALL hold their values between LATCH cycles.
REQ-034 The count comparison SHALL use the full 26-bit value; truncation before saturation is forbidden.

Reset
REQ-035 KEY0=0 SHALL immediately force the FSM to IDLE and clear all counters and synchronizer flops.
REQ-036 KEY0=0 SHALL immediately force freq_value=0, overflow=0, no_signal=0, valid=0 and busy=0.
REQ-037 KEY0 asserted mid-GATE SHALL discard the partial count with no valid pulse.
REQ-038 After KEY0 rises, the block SHALL require a new start_evt before measuring.

Verification (GATE_CYCLES=100, MAX_DISPLAY=999 unless stated)
REQ-039 Basic measurement: INPUT_CLK period 10 cycles, KEY1 pulsed low -> one valid pulse, freq_value=10, overflow=0, no_signal=0, busy low after LATCH.
REQ-040 No signal: INPUT_CLK held 0, KEY1 pulsed -> valid exactly 100 cycles after ARM entry, freq_value=0, no_signal=1.
REQ-041 Saturation: MAX_DISPLAY=20, INPUT_CLK period 4 -> freq_value=20, overflow=1.
REQ-042 Continuous mode: cont_mode=1, period 5 -> repeated valid pulses each with freq_value=20; clearing cont_mode mid-GATE -> one final valid pulse, then IDLE.
REQ-043 Reset mid-operation: KEY0 low at g=50 -> busy=0 and outputs 0 within the same cycle, no valid; a following KEY1 press yields a normal result.
REQ-044 Start ignored: a second KEY1 press during GATE -> exactly one valid pulse, with freq_value unchanged from the expected value.
